// File: rtl/mem_stage_wait.sv
// MEM/WB stage of the RV32 pipeline. It holds the data memory and the MEM/WB
// pipeline register. It supports sub-word loads and stores with byte lanes,
// detects misaligned accesses, and adds MEM_WAIT wait states per access
// through a small stall FSM.
module mem_stage_wait #(
    parameter int DEPTH_WORDS = 1024,
    parameter int MEM_WAIT    = 0,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        FlushM,
    input  logic        RegWriteM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [1:0]  ResultSrcM,
    input  logic [4:0]  RDM,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic        ValidW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RDW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic        MisalignW
);

    localparam logic [3:0] WAIT_C = 4'(MEM_WAIT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Returns 1 when funct3 is not a legal access type, or when the address
    // does not match the natural alignment of the access size.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a,
                                           input logic st);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = a[0];
            3'b010:  bad = (a != 2'b00);
            3'b100:  bad = st;
            3'b101:  bad = st | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Selects the byte or halfword addressed by a[1:0] and extends it.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [2:0] f3,
                                                 input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            2'b11:   b = w[31:24];
            default: b = 8'h00;
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Returns the byte-lane enables for a store of the given size.
    function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001 << a;
            2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    logic [31:0]       mem_r [DEPTH_WORDS];
    state_t            state_r;
    state_t            state_nx_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_nx_s;
    logic              stall_s;
    logic              live_s;
    logic              mem_op_s;
    logic              misalign_s;
    logic              access_s;
    logic              commit_s;
    logic [ADDR_W-1:0] word_idx_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       wdata_s;
    logic [3:0]        mask_s;
    logic              unused_s;

    assign live_s     = ValidM & ~FlushM;
    assign mem_op_s   = MemReadM | MemWriteM;
    assign misalign_s = mem_op_s & is_misaligned(Funct3M, ALUResultM[1:0], MemWriteM);
    assign access_s   = live_s & mem_op_s & ~misalign_s;
    // Upper address bits are ignored, so addresses wrap inside the array.
    assign word_idx_s = ALUResultM[ADDR_W+1:2];
    assign rd_word_s  = mem_r[word_idx_s];
    assign mask_s     = store_mask(Funct3M[1:0], ALUResultM[1:0]);
    assign wdata_s    = (Funct3M[1:0] == 2'b00) ? {4{WriteDataM[7:0]}} :
                        (Funct3M[1:0] == 2'b01) ? {2{WriteDataM[15:0]}} : WriteDataM;
    // A store commits only on its completing (non-stalled) edge. Reset cancels it.
    assign commit_s   = access_s & MemWriteM & ~stall_s & ~rst;
    assign StallM     = stall_s;
    assign unused_s   = ^ALUResultM[31:ADDR_W+2];

    // Next-state and stall logic of the wait-state FSM.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        stall_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (access_s && (WAIT_C != 4'd0)) begin
                    state_nx_s = ST_WAIT;
                    cnt_nx_s   = 4'd1;
                    stall_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (!access_s) begin
                    // A flush or a dropped request aborts the pending access.
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 4'd0;
                end else if (cnt_r < WAIT_C) begin
                    state_nx_s = ST_WAIT;
                    cnt_nx_s   = cnt_r + 4'd1;
                    stall_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 4'd0;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Data memory write port. Only the addressed byte lanes are written.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    // MEM/WB register. It loads a bubble while stalled or when there is no live instruction.
    always_ff @(posedge clk) begin
        if (rst || stall_s || !live_s) begin
            ValidW     <= 1'b0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RDW        <= 5'd0;
            PCPlus4W   <= 32'h0000_0000;
            ALUResultW <= 32'h0000_0000;
            ReadDataW  <= 32'h0000_0000;
            MisalignW  <= 1'b0;
        end else begin
            ValidW     <= 1'b1;
            RegWriteW  <= RegWriteM & ~misalign_s;
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            PCPlus4W   <= PCPlus4M;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (MemReadM && !misalign_s) ?
                          load_extract(rd_word_s, Funct3M, ALUResultM[1:0]) : 32'h0000_0000;
            MisalignW  <= misalign_s;
        end
    end

endmodule

// File: tb/tb_mem_stage_wait.sv
// Testbench for mem_stage_wait. Three instances exercise different
// configurations: (1024 words, 0 wait), (1024 words, 2 wait) and
// (16 words, 3 wait). Only the selected instance sees ValidM. Expected
// results come from a byte-addressed memory model and the timing rules for
// stalls.
module tb_mem_stage_wait;

    typedef struct {
        logic        v;
        logic        rw;
        logic        mis;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] data;
    } wexp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld, flush, rw, mr, mw;
    logic [2:0]  f3;
    logic [1:0]  rs;
    logic [4:0]  rdst;
    logic [31:0] pc, addr, wd;
    int          sel;

    logic        stall_o  [3];
    logic        validw_o [3];
    logic        regw_o   [3];
    logic        mis_o    [3];
    logic [1:0]  rsw_o    [3];
    logic [4:0]  rdw_o    [3];
    logic [31:0] pcw_o    [3];
    logic [31:0] aluw_o   [3];
    logic [31:0] rdd_o    [3];

    int          nchk = 0;
    int          nfail = 0;
    logic [7:0]  mdl [3][4096];
    wexp_t       pend;
    int          pend_k = 0;
    bit          have_pend = 0;
    bit          plan_en = 0;
    logic [31:0] plan_val = 32'h0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage_wait #(
            .DEPTH_WORDS((g == 2) ? 16 : 1024),
            .MEM_WAIT   ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .ValidM    (vld & (sel == g)),
            .FlushM    (flush),
            .RegWriteM (rw),
            .MemReadM  (mr),
            .MemWriteM (mw),
            .Funct3M   (f3),
            .ResultSrcM(rs),
            .RDM       (rdst),
            .PCPlus4M  (pc),
            .ALUResultM(addr),
            .WriteDataM(wd),
            .StallM    (stall_o[g]),
            .ValidW    (validw_o[g]),
            .RegWriteW (regw_o[g]),
            .ResultSrcW(rsw_o[g]),
            .RDW       (rdw_o[g]),
            .PCPlus4W  (pcw_o[g]),
            .ALUResultW(aluw_o[g]),
            .ReadDataW (rdd_o[g]),
            .MisalignW (mis_o[g])
        );
    end

    function automatic int waits_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic int unsigned bytes_of(input int k);
        return (k == 2) ? 64 : 4096;
    endfunction

    // Legality and natural-alignment rule, stated in terms of access size.
    function automatic bit model_bad(input logic [2:0] c, input logic [31:0] a, input logic st);
        bit legal;
        int size;
        legal = st ? (c <= 3'd2) : (c inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << c[1:0];
        return !legal || ((int'(a[2:0]) % size) != 0);
    endfunction

    function automatic logic [31:0] model_load(input int k, input logic [2:0] c, input logic [31:0] a);
        int          size;
        logic [31:0] v;
        int unsigned idx;
        size = 1 << c[1:0];
        v = 32'h0;
        for (int i = 0; i < size; i++) begin
            idx = (a + 32'(i)) % bytes_of(k);
            v = v | (32'(mdl[k][idx]) << (8 * i));
        end
        if (!c[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic model_store(input int k, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        int          size;
        int unsigned idx;
        size = 1 << c[1:0];
        for (int i = 0; i < size; i++) begin
            idx = (a + 32'(i)) % bytes_of(k);
            mdl[k][idx] = d[8*i +: 8];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input int k, input wexp_t e);
        chk("ValidW",     32'(validw_o[k]), 32'(e.v));
        chk("RegWriteW",  32'(regw_o[k]),   32'(e.rw));
        chk("MisalignW",  32'(mis_o[k]),    32'(e.mis));
        chk("ResultSrcW", 32'(rsw_o[k]),    32'(e.rs));
        chk("RDW",        32'(rdw_o[k]),    32'(e.rd));
        chk("PCPlus4W",   pcw_o[k],  e.pc);
        chk("ALUResultW", aluw_o[k], e.alu);
        chk("ReadDataW",  rdd_o[k],  e.data);
    endtask

    task automatic check_pending();
        if (have_pend) begin
            check_w(pend_k, pend);
            if (plan_en) chk("plan_data", rdd_o[pend_k], plan_val);
        end
        plan_en = 0;
    endtask

    task automatic want(input logic [31:0] val);
        plan_en  = 1;
        plan_val = val;
    endtask

    // Present one instruction and hold it until the access completes.
    task automatic step(input int k, input logic v, input logic f, input logic w_en,
                        input logic r_op, input logic w_op, input logic [2:0] c,
                        input logic [1:0] src, input logic [4:0] d, input logic [31:0] a,
                        input logic [31:0] data);
        wexp_t e;
        bit    live, memop, bad, acc;
        int    nst;
        sel = k; vld = v; flush = f; rw = w_en; mr = r_op; mw = w_op; f3 = c;
        rs = src; rdst = d; addr = a; wd = data; pc = $urandom;
        live  = v && !f;
        memop = r_op || w_op;
        bad   = memop && model_bad(c, a, w_op);
        acc   = live && memop && !bad;
        nst   = acc ? waits_of(k) : 0;
        e.v    = live;
        e.rw   = live && w_en && !bad;
        e.mis  = live && bad;
        e.rs   = live ? src : 2'b00;
        e.rd   = live ? d : 5'd0;
        e.pc   = live ? pc : 32'h0;
        e.alu  = live ? a : 32'h0;
        e.data = (live && r_op && !bad) ? model_load(k, c, a) : 32'h0;
        for (int i = 0; i <= nst; i++) begin
            @(negedge clk);
            chk("StallM", 32'(stall_o[k]), 32'(i < nst));
            if (i == 0) check_pending();
            else chk("stall_bubble", 32'(validw_o[k]), 32'h0);
            @(posedge clk); #1;
        end
        if (acc && w_op) model_store(k, c, a, data);
        pend = e; pend_k = k; have_pend = 1;
    endtask

    task automatic sw(input int k, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        step(k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c, 2'b00, 5'd0, a, d);
    endtask

    task automatic ld(input int k, input logic [2:0] c, input logic [31:0] a);
        step(k, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, c, 2'b01, 5'd5, a, 32'h0);
    endtask

    // Store on the 3-wait instance, killed in its third M cycle by rst or FlushM.
    task automatic abort_sw(input bit use_rst, input logic [31:0] a, input logic [31:0] d);
        wexp_t z;
        z = '{v: 1'b0, rw: 1'b0, mis: 1'b0, rs: 2'b00, rd: 5'd0, pc: 32'h0, alu: 32'h0, data: 32'h0};
        sel = 2; vld = 1'b1; flush = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b1; f3 = 3'b010;
        rs = 2'b00; rdst = 5'd0; addr = a; wd = d; pc = $urandom;
        @(negedge clk);
        chk("abort_stall0", 32'(stall_o[2]), 32'h1);
        check_pending();
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_stall1", 32'(stall_o[2]), 32'h1);
        chk("abort_bubble", 32'(validw_o[2]), 32'h0);
        @(posedge clk); #1;
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; vld = 1'b0; mw = 1'b0;
        @(negedge clk);
        chk("abort_stall_after", 32'(stall_o[2]), 32'h0);
        check_w(2, z);
        @(posedge clk); #1;
        pend = z; pend_k = 2; have_pend = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          op;
        logic [31:0] ra;
        rst = 1'b1; vld = 1'b0; flush = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0;
        f3 = 3'b000; rs = 2'b00; rdst = 5'd0; pc = 32'h0; addr = 32'h0; wd = 32'h0; sel = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("reset_StallM", 32'(stall_o[k]), 32'h0);
            chk("reset_ValidW", 32'(validw_o[k]), 32'h0);
            chk("reset_ReadDataW", rdd_o[k], 32'h0);
            chk("reset_PCPlus4W", pcw_o[k], 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-wait word and sub-word traffic.
        sw(0, 3'b010, 32'h10, 32'hDEADBEEF);
        ld(0, 3'b010, 32'h10); want(32'hDEADBEEF);
        sw(0, 3'b000, 32'h13, 32'h00000080);
        ld(0, 3'b000, 32'h13); want(32'hFFFFFF80);
        ld(0, 3'b100, 32'h13); want(32'h00000080);
        ld(0, 3'b001, 32'h12); want(32'hFFFF80AD);
        ld(0, 3'b101, 32'h10); want(32'h0000BEEF);
        // Misaligned and illegal accesses.
        ld(0, 3'b010, 32'h12);
        sw(0, 3'b001, 32'h11, 32'h0000FFFF);
        ld(0, 3'b011, 32'h10);
        ld(0, 3'b010, 32'h10); want(32'h80ADBEEF);

        // Two wait states, followed by a non-memory instruction.
        sw(1, 3'b010, 32'h30, 32'h0BADF00D);
        ld(1, 3'b010, 32'h30); want(32'h0BADF00D);
        step(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 5'd9, 32'h1234, 32'h0);
        want(32'h0);
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 5'd0, 32'h0, 32'h0);

        // Three wait states: aborted stores, then address wrap on 16 words.
        sw(2, 3'b010, 32'h20, 32'h11111111);
        abort_sw(1'b1, 32'h20, 32'h12345678);
        ld(2, 3'b010, 32'h20); want(32'h11111111);
        abort_sw(1'b0, 32'h20, 32'h12345678);
        ld(2, 3'b010, 32'h20); want(32'h11111111);
        sw(2, 3'b010, 32'h40, 32'hA5A5A5A5);
        ld(2, 3'b010, 32'h00); want(32'hA5A5A5A5);

        // Randomized traffic against the model on every instance.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) sw(k, 3'b010, 32'(4 * i), $urandom);
            for (int i = 0; i < 60; i++) begin
                op = $urandom_range(0, 2);
                ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
                step(k, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 1)), (op == 1), (op == 2),
                     3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                     5'($urandom_range(0, 31)), ra, $urandom);
            end
        end
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 5'd0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
